// File: rtl/dcache_defs.sv
// Shared definitions for the direct-mapped write-back data cache:
// default field widths and the controller state encoding.
package dcache_defs;

    localparam int unsigned ADDR_W      = 8;
    localparam int unsigned DEF_INDEX_W = 3;
    localparam int unsigned OFFSET_W    = 2;
    localparam int unsigned BLOCK_W     = 32;

    typedef enum logic [1:0] {
        IDLE,
        WRITEBACK,
        FETCH,
        UPDATE
    } cache_state_t;

endpackage

// File: rtl/dcache_store.sv
// Line storage for the data cache: valid/dirty/tag/data arrays with async clear,
// one combinational line read, a byte write port and a whole-line fill port.
module dcache_store
    import dcache_defs::*;
#(
    parameter int unsigned INDEX_W = DEF_INDEX_W,
    parameter int unsigned TAG_W   = ADDR_W - DEF_INDEX_W - OFFSET_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [INDEX_W-1:0]   index,
    output logic                 line_valid,
    output logic                 line_dirty,
    output logic [TAG_W-1:0]     line_tag,
    output logic [BLOCK_W-1:0]   line_data,
    input  logic                 byte_we,
    input  logic [OFFSET_W-1:0]  byte_sel,
    input  logic [7:0]           byte_data,
    input  logic                 fill_we,
    input  logic [TAG_W-1:0]     fill_tag,
    input  logic [BLOCK_W-1:0]   fill_data
);

    localparam int unsigned LINES = 1 << INDEX_W;

    logic                valid_q [LINES];
    logic                dirty_q [LINES];
    logic [TAG_W-1:0]    tag_q   [LINES];
    logic [BLOCK_W-1:0]  data_q  [LINES];

    assign line_valid = valid_q[index];
    assign line_dirty = dirty_q[index];
    assign line_tag   = tag_q[index];
    assign line_data  = data_q[index];

    // A fill always wins; the controller never requests both in one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < LINES; i++) begin
                valid_q[i] <= 1'b0;
                dirty_q[i] <= 1'b0;
                tag_q[i]   <= '0;
                data_q[i]  <= '0;
            end
        end else if (fill_we) begin
            data_q[index]  <= fill_data;
            tag_q[index]   <= fill_tag;
            valid_q[index] <= 1'b1;
            dirty_q[index] <= 1'b0;
        end else if (byte_we) begin
            data_q[index][{byte_sel, 3'b000} +: 8] <= byte_data;
            dirty_q[index] <= 1'b1;
        end
    end

endmodule

// File: rtl/dcache_controller.sv
// Direct-mapped write-back data cache controller: zero-stall byte hits, and on a
// miss an optional writeback then block fetch over the BUSYWAIT handshake.
module dcache_controller
    import dcache_defs::*;
#(
    parameter int unsigned INDEX_W = DEF_INDEX_W
) (
    input  logic                           CLK,
    input  logic                           RESET_N,
    input  logic                           READ,
    input  logic                           WRITE,
    input  logic [ADDR_W-1:0]              ADDRESS,
    input  logic [7:0]                     WRITEDATA,
    output logic [7:0]                     READDATA,
    output logic                           BUSYWAIT,
    output logic                           MEM_READ,
    output logic                           MEM_WRITE,
    output logic [ADDR_W-OFFSET_W-1:0]     MEM_ADDRESS,
    output logic [BLOCK_W-1:0]             MEM_WRITEDATA,
    input  logic [BLOCK_W-1:0]             MEM_READDATA,
    input  logic                           MEM_BUSYWAIT
);

    localparam int unsigned TAG_W = ADDR_W - INDEX_W - OFFSET_W;

    cache_state_t          state;
    logic [TAG_W-1:0]      addr_tag;
    logic [INDEX_W-1:0]    addr_index;
    logic [OFFSET_W-1:0]   addr_offset;
    logic                  line_valid;
    logic                  line_dirty;
    logic [TAG_W-1:0]      line_tag;
    logic [BLOCK_W-1:0]    line_data;
    logic                  hit;
    logic                  request;

    assign addr_tag    = ADDRESS[ADDR_W-1 -: TAG_W];
    assign addr_index  = ADDRESS[OFFSET_W +: INDEX_W];
    assign addr_offset = ADDRESS[OFFSET_W-1:0];
    assign hit         = line_valid && (line_tag == addr_tag);
    assign request     = READ || WRITE;

    dcache_store #(
        .INDEX_W (INDEX_W),
        .TAG_W   (TAG_W)
    ) u_store (
        .clk        (CLK),
        .rst_n      (RESET_N),
        .index      (addr_index),
        .line_valid (line_valid),
        .line_dirty (line_dirty),
        .line_tag   (line_tag),
        .line_data  (line_data),
        .byte_we    ((state == IDLE) && WRITE && hit),
        .byte_sel   (addr_offset),
        .byte_data  (WRITEDATA),
        .fill_we    (state == UPDATE),
        .fill_tag   (addr_tag),
        .fill_data  (MEM_READDATA)
    );

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE:      if (request && !hit) state <= (line_valid && line_dirty) ? WRITEBACK : FETCH;
                WRITEBACK: if (!MEM_BUSYWAIT) state <= FETCH;
                FETCH:     if (!MEM_BUSYWAIT) state <= UPDATE;
                UPDATE:    state <= IDLE;
                default:   state <= IDLE;
            endcase
        end
    end

    // Outputs are decoded from state and the held cpu request; gating on RESET_N
    // makes an asserted reset drop every strobe in the same instant.
    always_comb begin
        READDATA      = '0;
        BUSYWAIT      = 1'b0;
        MEM_READ      = 1'b0;
        MEM_WRITE     = 1'b0;
        MEM_ADDRESS   = '0;
        MEM_WRITEDATA = '0;
        if (RESET_N) begin
            case (state)
                IDLE: begin
                    BUSYWAIT = request && !hit;
                    READDATA = line_data[{addr_offset, 3'b000} +: 8];
                end
                WRITEBACK: begin
                    BUSYWAIT      = 1'b1;
                    MEM_WRITE     = 1'b1;
                    MEM_ADDRESS   = {line_tag, addr_index};
                    MEM_WRITEDATA = line_data;
                end
                FETCH: begin
                    BUSYWAIT    = 1'b1;
                    MEM_READ    = 1'b1;
                    MEM_ADDRESS = {addr_tag, addr_index};
                end
                UPDATE: begin
                    BUSYWAIT = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dcache_controller.sv
// Directed self-checking bench for dcache_controller with a 4-cycle block memory model.
module tb_dcache_controller;

    logic        CLK = 1'b0;
    logic        RESET_N;
    logic        READ;
    logic        WRITE;
    logic [7:0]  ADDRESS;
    logic [7:0]  WRITEDATA;
    logic [7:0]  READDATA;
    logic        BUSYWAIT;
    logic        MEM_READ;
    logic        MEM_WRITE;
    logic [5:0]  MEM_ADDRESS;
    logic [31:0] MEM_WRITEDATA;
    logic [31:0] MEM_READDATA;
    logic        MEM_BUSYWAIT;

    int n_tests = 0;
    int n_fail  = 0;

    dcache_controller #(.INDEX_W(3)) dut (
        .CLK           (CLK),
        .RESET_N       (RESET_N),
        .READ          (READ),
        .WRITE         (WRITE),
        .ADDRESS       (ADDRESS),
        .WRITEDATA     (WRITEDATA),
        .READDATA      (READDATA),
        .BUSYWAIT      (BUSYWAIT),
        .MEM_READ      (MEM_READ),
        .MEM_WRITE     (MEM_WRITE),
        .MEM_ADDRESS   (MEM_ADDRESS),
        .MEM_WRITEDATA (MEM_WRITEDATA),
        .MEM_READDATA  (MEM_READDATA),
        .MEM_BUSYWAIT  (MEM_BUSYWAIT)
    );

    always #5 CLK = ~CLK;

    // Block memory: busy for the first 3 cycles of each request, done on the 4th.
    logic [31:0] mem [64];
    logic [1:0]  mem_prev = 2'b00;
    int          mem_cnt = 0;
    logic [31:0] mem_rdata = '0;
    logic [5:0]  fetch_addr = '0;
    logic [5:0]  wb_addr = '0;
    logic [31:0] wb_data = '0;
    int          n_fetch = 0;
    int          n_wb = 0;
    int          n_both = 0;
    int          n_strobe = 0;

    assign MEM_READDATA = mem_rdata;
    assign MEM_BUSYWAIT = (MEM_READ || MEM_WRITE) &&
                          (({MEM_READ, MEM_WRITE} != mem_prev) || (mem_cnt < 3));

    always @(posedge CLK) begin
        mem_cnt  <= ({MEM_READ, MEM_WRITE} != mem_prev) ? 1 : mem_cnt + 1;
        mem_prev <= {MEM_READ, MEM_WRITE};
        if (MEM_READ && MEM_WRITE) n_both <= n_both + 1;
        if (MEM_READ || MEM_WRITE) n_strobe <= n_strobe + 1;
        if (MEM_READ && !MEM_BUSYWAIT) begin
            mem_rdata  <= mem[MEM_ADDRESS];
            fetch_addr <= MEM_ADDRESS;
            n_fetch    <= n_fetch + 1;
        end
        if (MEM_WRITE && !MEM_BUSYWAIT) begin
            mem[MEM_ADDRESS] <= MEM_WRITEDATA;
            wb_addr <= MEM_ADDRESS;
            wb_data <= MEM_WRITEDATA;
            n_wb    <= n_wb + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Presents an access at a negedge and waits (bounded) for BUSYWAIT low;
    // the request stays asserted across the following posedge.
    task automatic access(input logic rd, input logic wr, input logic [7:0] addr,
                          input logic [7:0] wdata, output logic first_busy, output int stall);
        @(negedge CLK);
        READ = rd; WRITE = wr; ADDRESS = addr; WRITEDATA = wdata;
        #1;
        first_busy = BUSYWAIT;
        stall = 0;
        while (BUSYWAIT && stall < 50) begin
            @(negedge CLK);
            #1;
            stall++;
        end
        if (stall >= 50) check("busywait_timeout", 32'(stall), 32'd0);
    endtask

    task automatic release_cpu();
        @(negedge CLK);
        READ = 1'b0; WRITE = 1'b0;
    endtask

    logic fb;
    int   st;
    int   f0, w0, s0;

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = '0;
        mem[6'h01] = 32'h44332211;
        mem[6'h09] = 32'h00000000;
        mem[6'h12] = 32'h11223344;
        mem[6'h1A] = 32'hDEADBEEF;

        RESET_N = 1'b0; READ = 1'b0; WRITE = 1'b0; ADDRESS = '0; WRITEDATA = '0;
        repeat (2) @(negedge CLK);
        #1;
        check("rst_busywait", 32'(BUSYWAIT), 32'd0);
        check("rst_readdata", 32'(READDATA), 32'd0);
        check("rst_strobes",  32'({MEM_READ, MEM_WRITE}), 32'd0);
        check("rst_mem_addr", 32'(MEM_ADDRESS), 32'd0);
        check("rst_mem_wdata", MEM_WRITEDATA, 32'd0);
        @(negedge CLK);
        RESET_N = 1'b1;

        // Cold read miss
        f0 = n_fetch; w0 = n_wb;
        access(1'b1, 1'b0, 8'h05, 8'h00, fb, st);
        check("miss_first_busy", 32'(fb), 32'd1);
        check("miss_stall", 32'(st), 32'd6);
        check("miss_readdata", 32'(READDATA), 32'h22);
        check("miss_fetch_addr", 32'(fetch_addr), 32'h01);
        check("miss_fetch_cnt", 32'(n_fetch - f0), 32'd1);
        check("miss_no_wb", 32'(n_wb - w0), 32'd0);
        release_cpu();

        // Read hit
        s0 = n_strobe;
        access(1'b1, 1'b0, 8'h07, 8'h00, fb, st);
        check("hit_busy", 32'(fb), 32'd0);
        check("hit_readdata", 32'(READDATA), 32'h44);
        release_cpu();
        check("hit_no_strobe", 32'(n_strobe - s0), 32'd0);

        // Write hit, then read back
        access(1'b0, 1'b1, 8'h06, 8'hAB, fb, st);
        check("whit_busy", 32'(fb), 32'd0);
        release_cpu();
        access(1'b1, 1'b0, 8'h06, 8'h00, fb, st);
        check("whit_readback_busy", 32'(fb), 32'd0);
        check("whit_readback", 32'(READDATA), 32'hAB);
        release_cpu();
        check("whit_no_strobe", 32'(n_strobe - s0), 32'd0);

        // Dirty eviction
        f0 = n_fetch; w0 = n_wb;
        access(1'b1, 1'b0, 8'h25, 8'h00, fb, st);
        check("evict_stall", 32'(st), 32'd10);
        check("evict_wb_cnt", 32'(n_wb - w0), 32'd1);
        check("evict_wb_addr", 32'(wb_addr), 32'h01);
        check("evict_wb_data", wb_data, 32'h44AB2211);
        check("evict_fetch_addr", 32'(fetch_addr), 32'h09);
        check("evict_readdata", 32'(READDATA), 32'h00);
        release_cpu();

        // Write miss to a clean line
        f0 = n_fetch; w0 = n_wb;
        access(1'b0, 1'b1, 8'h48, 8'h5A, fb, st);
        check("wmiss_stall", 32'(st), 32'd6);
        check("wmiss_no_wb", 32'(n_wb - w0), 32'd0);
        check("wmiss_fetch_addr", 32'(fetch_addr), 32'h12);
        release_cpu();
        access(1'b1, 1'b0, 8'h48, 8'h00, fb, st);
        check("wmiss_read_busy", 32'(fb), 32'd0);
        check("wmiss_read", 32'(READDATA), 32'h5A);
        release_cpu();
        access(1'b1, 1'b0, 8'h49, 8'h00, fb, st);
        check("wmiss_read_b1", 32'(READDATA), 32'h33);
        release_cpu();

        // Replayed write left the line dirty: evicting it writes back the merged block
        w0 = n_wb;
        access(1'b1, 1'b0, 8'h68, 8'h00, fb, st);
        check("wmiss_evict_stall", 32'(st), 32'd10);
        check("wmiss_evict_wb_addr", 32'(wb_addr), 32'h12);
        check("wmiss_evict_wb_data", wb_data, 32'h1122335A);
        check("wmiss_evict_read", 32'(READDATA), 32'hEF);
        release_cpu();

        // Reset asserted while fetching
        @(negedge CLK);
        READ = 1'b1; ADDRESS = 8'h05;
        repeat (2) @(negedge CLK);
        #1;
        check("rstf_in_fetch", 32'(MEM_READ), 32'd1);
        RESET_N = 1'b0;
        #1;
        check("rstf_mem_read", 32'(MEM_READ), 32'd0);
        check("rstf_busywait", 32'(BUSYWAIT), 32'd0);
        @(negedge CLK);
        READ = 1'b0;
        RESET_N = 1'b1;
        w0 = n_wb;
        access(1'b1, 1'b0, 8'h05, 8'h00, fb, st);
        check("rstf_remiss", 32'(fb), 32'd1);
        check("rstf_stall", 32'(st), 32'd6);
        check("rstf_no_wb", 32'(n_wb - w0), 32'd0);
        check("rstf_readdata", 32'(READDATA), 32'h22);
        release_cpu();

        check("strobes_exclusive", 32'(n_both), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
